// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller and the ALU:
// opcodes, funct codes, ALU control codes, FSM state and ALUOp enums.
// Build option: MC_CTRL_ADDI_EN adds the ADDIEX/ADDIWB states for addi.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALUC_AND = 3'b000;
    localparam logic [2:0] ALUC_OR  = 3'b001;
    localparam logic [2:0] ALUC_ADD = 3'b010;
    localparam logic [2:0] ALUC_UND = 3'b011;
    localparam logic [2:0] ALUC_SUB = 3'b110;
    localparam logic [2:0] ALUC_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_JUMP
`ifdef MC_CTRL_ADDI_EN
        ,
        S_ADDIEX,
        S_ADDIWB
`endif
    } state_t;

    // ALUOp 00 is add so states that do not name an ALU operation get add
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle: instruction fields and zero flag in,
// mux selects, write enables and ALU control out.
interface mc_controller_if;

    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic [2:0] ALUControl;
    logic       PCEn;

    // Datapath side: drives instruction fields, receives controls
    modport master (
        output Op, Funct, Zero,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
        input  ALUSrcA, ALUSrcB, PCSrc, ALUControl, PCEn
    );

    // Controller side
    modport slave (
        input  Op, Funct, Zero,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
        output ALUSrcA, ALUSrcB, PCSrc, ALUControl, PCEn
    );

endinterface

// File: rtl/alu_decoder.sv
// Maps ALUOp and the instruction funct field to the 3-bit ALU control code.
module alu_decoder
    import mips_pkg::*;
(
    input  aluop_t     alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    // Fixed add/sub for address and branch work, funct-driven for R-type
    always_comb begin
        alu_control = ALUC_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALUC_ADD;
            ALUOP_SUB: alu_control = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALUC_ADD;
                    FUNCT_SUB: alu_control = ALUC_SUB;
                    FUNCT_AND: alu_control = ALUC_AND;
                    FUNCT_OR:  alu_control = ALUC_OR;
                    FUNCT_SLT: alu_control = ALUC_SLT;
                    default:   alu_control = ALUC_UND;
                endcase
            end
            default: alu_control = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: Moore FSM whose outputs decode straight
// from the current state. Build option MC_CTRL_ADDI_EN enables the addi path;
// without it addi decodes as a NOP.
module mc_controller
    import mips_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    mc_controller_if.slave bus
);

    state_t state;
    state_t state_nxt;
    aluop_t alu_op;
    logic   pc_write;
    logic   branch;
    logic   ir_write;
    logic   mem_write;
    logic   reg_write;
    logic   iord;
    logic   reg_dst;
    logic   mem_to_reg;
    logic   alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;

    // State register; reset lands in FETCH at once, even mid-instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    // Next-state: opcode steers DECODE and MEMADR, all else is a fixed chain
    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH: state_nxt = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXECUTE;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      state_nxt = S_ADDIEX;
`endif
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR:  state_nxt = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_nxt = S_MEMWB;
            S_EXECUTE: state_nxt = S_ALUWB;
`ifdef MC_CTRL_ADDI_EN
            S_ADDIEX:  state_nxt = S_ADDIWB;
`endif
            default:   state_nxt = S_FETCH;
        endcase
    end

    // Output decode: every control defaults to 0 (ALUOp 0 = add)
    always_comb begin
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_op     = ALUOP_ADD;
        pc_write   = 1'b0;
        branch     = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b = 2'b01;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
`ifdef MC_CTRL_ADDI_EN
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_ADDIWB: reg_write = 1'b1;
`endif
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (bus.Funct),
        .alu_control (bus.ALUControl)
    );

    // Write enables are masked while reset is held so FETCH's strobes stay quiet
    assign bus.IRWrite  = ir_write  & rst_n;
    assign bus.MemWrite = mem_write & rst_n;
    assign bus.RegWrite = reg_write & rst_n;
    assign bus.PCEn     = (pc_write | (branch & bus.Zero)) & rst_n;

    assign bus.IorD     = iord;
    assign bus.RegDst   = reg_dst;
    assign bus.MemtoReg = mem_to_reg;
    assign bus.ALUSrcA  = alu_src_a;
    assign bus.ALUSrcB  = alu_src_b;
    assign bus.PCSrc    = pc_src;

endmodule
